// File: rtl/reaction_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_ctrl -- human reaction-time tester.
//
// A start press arms a pseudo-random pre-light delay (MIN_DELAY_MS plus a
// 0..2047 ms random part taken from a free-running LFSR).  When the delay
// expires the lamp lights and a 4-digit BCD millisecond counter runs until the
// stop button is pressed or the count saturates at 9999.
//
// Optional feature (macro CHEAT_DETECT_EN): a stop press while waiting for the
// lamp enters a CHEAT state that shows 9999 and raises the cheat flag.  With
// the macro undefined the press is ignored and cheat is constant 0.
//
// Parameters
//   TICK_DIV      clk cycles per 1 ms tick
//   MIN_DELAY_MS  fixed part of the pre-light delay in ms
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   start, stop            debounced, synchronized button levels
//   led                    stimulus lamp, high only while the counter runs
//   bcd3..bcd0             elapsed ms, thousands..units, one BCD digit each
//   busy                   high while waiting for the lamp or counting
//   cheat                  high after an early stop press (CHEAT_DETECT_EN)
// -----------------------------------------------------------------------------
module reaction_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic       led,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       busy,
    output logic       cheat
);

`ifdef CHEAT_DETECT_EN
    localparam logic CHEAT_EN = 1'b1;
`else
    localparam logic CHEAT_EN = 1'b0;
`endif

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              DW        = $clog2(MIN_DELAY_MS + 2048) + 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_CLR = {PW{1'b0}};
    localparam logic [DW-1:0]   MIN_DELAY = DW'(MIN_DELAY_MS);
    localparam logic [DW-1:0]   DELAY_ONE = DW'(1);
    localparam logic [DW-1:0]   DELAY_CLR = {DW{1'b0}};
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;
    localparam logic [15:0]     BCD_MAX   = 16'h9999;
    localparam logic [15:0]     BCD_LAST  = 16'h9998;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_CHEAT = 3'd4
    } state_t;

    // Decimal increment of a packed 4-digit BCD value.  A digit at (or, if
    // ever corrupted, above) 9 rolls to 0 and carries, so no digit can leave
    // the 0..9 range; a carry out of the top digit saturates at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        if (carry) begin
            r = BCD_MAX;
        end else begin
            r = r;
        end
        return r;
    endfunction

    state_t          state_r;
    logic [15:0]     lfsr_r;
    logic            start_prev_r;
    logic            stop_prev_r;
    logic            armed_r;
    logic [PW-1:0]   presc_r;
    logic [DW-1:0]   delay_r;
    logic [15:0]     bcd_r;
    logic            led_r;
    logic            busy_r;
    logic            cheat_r;

    logic            start_rise_s;
    logic            stop_rise_s;
    logic            tick_s;
    logic            lfsr_fb_s;

    // armed_r masks the first cycle after reset release, so a button already
    // held while reset was asserted is not mistaken for a fresh press.
    assign start_rise_s = armed_r & start & ~start_prev_r;
    assign stop_rise_s  = armed_r & stop  & ~stop_prev_r;
    assign tick_s       = (presc_r == TICK_LAST);
    // Fibonacci feedback from taps 16, 14, 13, 11.
    assign lfsr_fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

    assign led  = led_r;
    assign busy = busy_r;
    assign cheat = cheat_r & CHEAT_EN;
    assign bcd3 = bcd_r[15:12];
    assign bcd2 = bcd_r[11:8];
    assign bcd1 = bcd_r[7:4];
    assign bcd0 = bcd_r[3:0];

    // Previous-level registers for rising-edge detection of both buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev_r <= 1'b0;
            stop_prev_r  <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            start_prev_r <= start;
            stop_prev_r  <= stop;
            armed_r      <= 1'b1;
        end
    end

    // Free-running random source; the all-zero lock-up state reseeds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (lfsr_r == 16'h0000) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end
    end

    // Round controller: prescaler, delay countdown, BCD counter and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            presc_r <= PRESC_CLR;
            delay_r <= DELAY_CLR;
            bcd_r   <= 16'h0000;
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
            cheat_r <= 1'b0;
        end else begin
            case (state_r)
                // Start wins over a simultaneous stop in all idle states.
                ST_IDLE, ST_DONE, ST_CHEAT: begin
                    presc_r <= PRESC_CLR;
                    if (start_rise_s) begin
                        state_r <= ST_WAIT;
                        delay_r <= MIN_DELAY + DW'(lfsr_r[10:0]);
                        bcd_r   <= 16'h0000;
                        led_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        cheat_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (CHEAT_EN && stop_rise_s) begin
                        state_r <= ST_CHEAT;
                        presc_r <= PRESC_CLR;
                        bcd_r   <= BCD_MAX;
                        led_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        cheat_r <= 1'b1;
                    end else if (tick_s) begin
                        presc_r <= PRESC_CLR;
                        // A count of 1 becomes 0 on this tick: light the lamp.
                        if (delay_r <= DELAY_ONE) begin
                            state_r <= ST_RUN;
                            delay_r <= DELAY_CLR;
                            led_r   <= 1'b1;
                        end else begin
                            delay_r <= delay_r - DELAY_ONE;
                        end
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                ST_RUN: begin
                    // Stop is checked first so a coincident tick is dropped.
                    if (stop_rise_s) begin
                        state_r <= ST_DONE;
                        presc_r <= PRESC_CLR;
                        led_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (tick_s) begin
                        presc_r <= PRESC_CLR;
                        bcd_r   <= bcd_inc(bcd_r);
                        if (bcd_r == BCD_LAST) begin
                            state_r <= ST_DONE;
                            led_r   <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    presc_r <= PRESC_CLR;
                    led_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    cheat_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reaction_ctrl -- self-checking bench for reaction_ctrl with TICK_DIV=4 and
// MIN_DELAY_MS=2.  The expected lamp delay comes from a reference LFSR stepped
// from the spec's seed and tap list; expected digits come from elapsed cycles
// divided by the tick period, converted to decimal with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_reaction_ctrl;

    localparam int TD = 4;
    localparam int MD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        led;
    logic        busy;
    logic        cheat;
    logic [3:0]  bcd3, bcd2, bcd1, bcd0;
    logic [15:0] digits;
    logic [15:0] m_lfsr;

    int checks = 0;
    int errors = 0;
    int rj     = 0;

    assign digits = {bcd3, bcd2, bcd1, bcd0};

    reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(MD)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .led   (led),
        .bcd3  (bcd3),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .busy  (busy),
        .cheat (cheat)
    );

    always #5 clk = ~clk;

    // One LFSR step built from the tap positions 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 4; i++) fb = fb ^ v[taps[i] - 1];
        return {v[14:0], fb};
    endfunction

    // Reference value the DUT's random source holds in the current cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait a random time for a small random delay, press start, return delay.
    task automatic begin_round(output int d, input bit with_stop);
        int n;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        n = 0;
        while (m_lfsr[10:0] >= 11'd256 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        d = MD + int'(m_lfsr[10:0]);
        start = 1'b1;
        stop  = with_stop;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("led_low_after_start", led, 0);
        chk("cheat_clear_after_start", cheat, 0);
        chk("digits_clear_after_start", digits, 16'h0000);
    endtask

    // Follow the waiting phase until the lamp lights; optional button pokes.
    task automatic wait_led(input int d, input bit start_poke, input bit stop_poke);
        int n;
        n = 0;
        while (led !== 1'b1 && n < 4 * d + 16) begin
            chk("wait_digits_zero", digits, 16'h0000);
            chk("wait_busy", busy, 1);
            @(negedge clk);
            n++;
            if (start_poke && n == 1) start = 1'b0;
            if (start_poke && n == 2) start = 1'b1;
            if (start_poke && n == 3) start = 1'b0;
            if (stop_poke && n == 4) stop = 1'b1;
        end
        chk("led_rose", led, 1);
        chk("led_rise_time", (n >= 4 * d - 1) && (n <= 4 * d + 1), 1);
        rj = 0;
    endtask

    // Advance the running count to 'target' ticks, checking every cycle.
    task automatic run_to(input int target);
        int cnt;
        while (1) begin
            cnt = (rj / TD > 9999) ? 9999 : rj / TD;
            chk("run_digits", digits, to_bcd(cnt));
            chk("run_led", led, cnt < 9999);
            chk("run_busy", busy, cnt < 9999);
            if (cnt >= target) break;
            @(negedge clk);
            rj++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_digits", digits, 16'h0000);
        chk("reset_led", led, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cheat", cheat, 0);
        reset = 1'b0;

        // Round 1: start re-press in WAIT and RUN ignored; stop+start in RUN.
        begin_round(d, 1'b0);
        wait_led(d, 1'b1, 1'b0);
        run_to(10);
        start = 1'b1;
        run_to(12);
        start = 1'b0;
        run_to(37);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("stop_digits", digits, 16'h0037);
        chk("stop_led", led, 0);
        chk("stop_busy", busy, 0);
        stop = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_hold_digits", digits, 16'h0037);
        chk("done_hold_busy", busy, 0);

        // Round 2: start+stop together in DONE starts; run to saturation.
        begin_round(d, 1'b1);
        wait_led(d, 1'b0, 1'b0);
        run_to(9999);
        repeat (5) @(negedge clk);
        chk("sat_digits", digits, 16'h9999);
        chk("sat_led", led, 0);
        chk("sat_busy", busy, 0);

        // Round 3: stop press while waiting for the lamp.
        begin_round(d, 1'b0);
`ifdef CHEAT_DETECT_EN
        stop = 1'b1;
        @(negedge clk);
        chk("cheat_flag", cheat, 1);
        chk("cheat_digits", digits, 16'h9999);
        chk("cheat_busy", busy, 0);
        stop = 1'b0;
        for (int k = 0; k < 4 * d + 8; k++) begin
            chk("cheat_led_low", led, 0);
            @(negedge clk);
        end
        begin_round(d, 1'b0);
        wait_led(d, 1'b0, 1'b0);
`else
        wait_led(d, 1'b0, 1'b1);
`endif
        run_to(123);

        // Round 4: reset mid-run with start held through release.
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_run_digits", digits, 16'h0000);
        chk("rst_run_led", led, 0);
        chk("rst_run_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_digits", digits, 16'h0000);
        chk("rst_hold_busy", busy, 0);
        reset = 1'b0;
        stop  = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_start_no_round", busy, 0);
        chk("held_start_led", led, 0);
        begin_round(d, 1'b0);
        wait_led(d, 1'b0, 1'b0);
        run_to(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
